// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the fetch stage (and the branch resolver) and
// the branch predictor.
//   master : drives fetch_* and upd_*, observes pred_* and perf_*
//   slave  : the predictor; observes fetch_*/upd_*, drives pred_*/perf_*
// Signals:
//   fetch_valid/fetch_pc        PC looked up this cycle
//   pred_valid/pred_pc          prediction and the PC it belongs to
//   pred_pc_next/pred_taken     guessed next PC and direction
//   upd_valid/upd_pc/upd_target resolved branch, its PC and real next PC
//   upd_taken/upd_category      resolved direction and branch kind
//   upd_flush                   resolver saw a mispredict
//   perf_branches/mispredicts   saturating event counters
interface branch_predictor_if #(
  parameter int CNT_W = 32
);
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic [31:0]      pred_pc_next;
  logic             pred_taken;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic             upd_taken;
  logic [1:0]       upd_category;
  logic             upd_flush;
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_mispredicts;

  modport master (
    output fetch_valid, fetch_pc,
    output upd_valid, upd_pc, upd_target, upd_taken, upd_category, upd_flush,
    input  pred_valid, pred_pc, pred_pc_next, pred_taken,
    input  perf_branches, perf_mispredicts
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken, upd_category, upd_flush,
    output pred_valid, pred_pc, pred_pc_next, pred_taken,
    output perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit saturating direction counters.
// One fetch lookup per cycle, result registered one cycle later. Trained from
// the execute-stage resolver bundle.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bp   branch_predictor_if slave (fetch, prediction, update, perf counters)
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  localparam logic [1:0] CAT_NONE = 2'b00;
  localparam logic [1:0] CAT_COND = 2'b01;

  // Per-entry state that needs reset lives in generate-for registers below;
  // tag/target/category are plain arrays with no reset.
  logic             entry_valid [ENTRIES];
  logic [1:0]       entry_ctr   [ENTRIES];
  logic [TAG_W-1:0] tag_mem     [ENTRIES];
  logic [29:0]      target_mem  [ENTRIES];
  logic [1:0]       cat_mem     [ENTRIES];

  logic             pred_valid_reg;
  logic [31:0]      pred_pc_reg;
  logic [31:0]      pred_pc_next_reg;
  logic             pred_taken_reg;
  logic [CNT_W-1:0] perf_branches_reg;
  logic [CNT_W-1:0] perf_mispredicts_reg;

  // Address fields
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  assign fetch_idx = bp.fetch_pc[IDX_W+1:2];
  assign fetch_tag = bp.fetch_pc[31:IDX_W+2];
  assign upd_idx   = bp.upd_pc[IDX_W+1:2];
  assign upd_tag   = bp.upd_pc[31:IDX_W+2];

  // Low address bits never matter: instructions are word aligned.
  logic unused_low_bits;
  assign unused_low_bits = &{1'b0, bp.fetch_pc[1:0], bp.upd_pc[1:0], bp.upd_target[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup. The table is read combinationally before any same-cycle write
  // lands, so a lookup colliding with an update sees the old contents.
  // ---------------------------------------------------------------------------
  logic        fetch_hit;
  logic        fetch_taken;
  logic [31:0] fetch_next;

  always_comb begin
    fetch_hit   = entry_valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
    fetch_taken = fetch_hit && ((cat_mem[fetch_idx] != CAT_COND) || entry_ctr[fetch_idx][1]);
    fetch_next  = fetch_taken ? {target_mem[fetch_idx], 2'b00} : (bp.fetch_pc + 32'd4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_reg   <= 1'b0;
      pred_pc_reg      <= 32'd0;
      pred_pc_next_reg <= 32'd0;
      pred_taken_reg   <= 1'b0;
    end else begin
      // A flush means this cycle's fetch is on the wrong path.
      pred_valid_reg <= bp.fetch_valid && !bp.upd_flush;
      if (bp.fetch_valid) begin
        pred_pc_reg      <= bp.fetch_pc;
        pred_pc_next_reg <= fetch_next;
        pred_taken_reg   <= fetch_taken;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------------
  logic       upd_en;
  logic       upd_hit;
  logic       upd_alloc;
  logic       ctr_we;
  logic [1:0] ctr_cur;
  logic [1:0] ctr_wval;
  logic       tbl_we;

  always_comb begin
    upd_en    = bp.upd_valid && (bp.upd_category != CAT_NONE);
    upd_hit   = entry_valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    upd_alloc = upd_en && !upd_hit && bp.upd_taken;
    ctr_cur   = entry_ctr[upd_idx];
    ctr_wval  = ctr_cur;
    if (upd_alloc) begin
      ctr_wval = 2'b10;  // new entries start weakly taken
    end else if (bp.upd_taken) begin
      if (ctr_cur != 2'b11) ctr_wval = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_wval = ctr_cur - 2'd1;
    end
    // Counters only move for conditional branches (or on allocation).
    ctr_we = upd_alloc || (upd_en && upd_hit && (bp.upd_category == CAT_COND));
    // Any taken resolution refreshes target/category; on a hit the tag write
    // is a no-op, on a miss it is the allocation.
    tbl_we = upd_en && bp.upd_taken;
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic       valid_reg;
      logic [1:0] ctr_reg;
      logic       sel;

      assign sel = (upd_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          ctr_reg   <= 2'b01;
        end else begin
          if (sel && upd_alloc) valid_reg <= 1'b1;
          if (sel && ctr_we)    ctr_reg   <= ctr_wval;
        end
      end

      assign entry_valid[gi] = valid_reg;
      assign entry_ctr[gi]   = ctr_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst && tbl_we) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= bp.upd_target[31:2];
      cat_mem[upd_idx]    <= bp.upd_category;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters, saturating at all-ones
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_reg    <= '0;
      perf_mispredicts_reg <= '0;
    end else begin
      if (bp.upd_valid && (perf_branches_reg != '1))
        perf_branches_reg <= perf_branches_reg + 1'b1;
      if (bp.upd_valid && bp.upd_flush && (perf_mispredicts_reg != '1))
        perf_mispredicts_reg <= perf_mispredicts_reg + 1'b1;
    end
  end

  assign bp.pred_valid       = pred_valid_reg;
  assign bp.pred_pc          = pred_pc_reg;
  assign bp.pred_pc_next     = pred_pc_next_reg;
  assign bp.pred_taken       = pred_taken_reg;
  assign bp.perf_branches    = perf_branches_reg;
  assign bp.perf_mispredicts = perf_mispredicts_reg;
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  localparam int IDX_W   = 6;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.CNT_W(32)) bp ();

  branch_predictor #(.IDX_W(IDX_W), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model of the BTB
  logic             m_valid [ENTRIES];
  logic [TAG_W-1:0] m_tag   [ENTRIES];
  logic [29:0]      m_tgt   [ENTRIES];
  logic [1:0]       m_cat   [ENTRIES];
  logic [1:0]       m_ctr   [ENTRIES];
  logic [31:0]      h_pc, h_next, n_br, n_mp;
  logic             h_tk;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic [31:0] nx;
    logic        tk;
    logic [31:0] pb;
    logic [31:0] pm;
  } exp_t;
  exp_t sb[$];

  // One clock of stimulus: compute expected, push, advance, pop and compare.
  task automatic step(input logic r, input logic fv, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic utk, input logic [1:0] ucat, input logic ufl);
    exp_t e;
    int   fi, ui;
    logic hit, tk;
    rst             = r;
    bp.fetch_valid  = fv;
    bp.fetch_pc     = fpc;
    bp.upd_valid    = uv;
    bp.upd_pc       = upc;
    bp.upd_target   = utgt;
    bp.upd_taken    = utk;
    bp.upd_category = ucat;
    bp.upd_flush    = ufl;
    fi = int'(fpc[IDX_W+1:2]);
    ui = int'(upc[IDX_W+1:2]);
    if (r) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 2'b01;
      end
      h_pc = 0; h_next = 0; h_tk = 0; n_br = 0; n_mp = 0;
      e.pv = 1'b0;
    end else begin
      e.pv = fv && !ufl;
      if (fv) begin
        hit    = m_valid[fi] && (m_tag[fi] == fpc[31:IDX_W+2]);
        tk     = hit && (m_cat[fi] != 2'b01 || m_ctr[fi][1]);
        h_pc   = fpc;
        h_tk   = tk;
        h_next = tk ? {m_tgt[fi], 2'b00} : fpc + 32'd4;
      end
      if (uv && ucat != 2'b00) begin
        hit = m_valid[ui] && (m_tag[ui] == upc[31:IDX_W+2]);
        if (hit) begin
          if (ucat == 2'b01) begin
            if (utk && m_ctr[ui] != 2'b11) m_ctr[ui] = m_ctr[ui] + 2'd1;
            if (!utk && m_ctr[ui] != 2'b00) m_ctr[ui] = m_ctr[ui] - 2'd1;
          end
          if (utk) begin
            m_tgt[ui] = utgt[31:2];
            m_cat[ui] = ucat;
          end
        end else if (utk) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = upc[31:IDX_W+2];
          m_tgt[ui]   = utgt[31:2];
          m_cat[ui]   = ucat;
          m_ctr[ui]   = 2'b10;
        end
      end
      if (uv && n_br != 32'hFFFFFFFF) n_br = n_br + 1;
      if (uv && ufl && n_mp != 32'hFFFFFFFF) n_mp = n_mp + 1;
    end
    e.pc = h_pc; e.nx = h_next; e.tk = h_tk; e.pb = n_br; e.pm = n_mp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pred_valid", 32'(bp.pred_valid), 32'(e.pv));
    check("pred_pc", bp.pred_pc, e.pc);
    check("pred_pc_next", bp.pred_pc_next, e.nx);
    check("pred_taken", 32'(bp.pred_taken), 32'(e.tk));
    check("perf_branches", bp.perf_branches, e.pb);
    check("perf_mispredicts", bp.perf_mispredicts, e.pm);
    $display("cyc r=%0b fv=%0b fpc=%08h uv=%0b upc=%08h tk=%0b cat=%0d fl=%0b -> pv=%0b next=%08h ptk=%0b",
             r, fv, fpc, uv, upc, utk, ucat, ufl, bp.pred_valid, bp.pred_pc_next, bp.pred_taken);
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic [1:0] cat);
    step(1'b0, 1'b0, 32'd0, 1'b1, pc, tgt, tk, cat, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bp.fetch_valid = 0; bp.fetch_pc = 0; bp.upd_valid = 0; bp.upd_pc = 0;
    bp.upd_target = 0; bp.upd_taken = 0; bp.upd_category = 0; bp.upd_flush = 0;
    @(posedge clk); #1;
    // Reset with fetch and update active: update must be dropped.
    step(1'b1, 1'b1, 32'h1C000010, 1'b1, 32'h1C000010, 32'h1C000100, 1'b1, 2'b10, 1'b0);
    check("rst_pred_valid", 32'(bp.pred_valid), 32'd0);
    check("rst_pred_next", bp.pred_pc_next, 32'd0);

    fetch(32'h1C000000);
    check("first_valid", 32'(bp.pred_valid), 32'd1);
    check("first_next", bp.pred_pc_next, 32'h1C000004);
    check("first_perf", bp.perf_branches, 32'd0);
    fetch(32'h1C000010);
    check("rst_update_dropped", bp.pred_pc_next, 32'h1C000014);

    // Train conditional taken, predict two cycles later
    upd(32'h1C000010, 32'h1C000100, 1'b1, 2'b01);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
    fetch(32'h1C000010);
    check("alloc_taken", bp.pred_pc_next, 32'h1C000100);

    // Counter training: 10 -> 00
    upd(32'h1C000010, 32'h1C000014, 1'b0, 2'b01);
    upd(32'h1C000010, 32'h1C000014, 1'b0, 2'b01);
    fetch(32'h1C000010);
    check("ctr_low_fall", bp.pred_pc_next, 32'h1C000014);
    upd(32'h1C000010, 32'h1C000014, 1'b0, 2'b01);  // saturate at 00
    for (int i = 0; i < 4; i++) upd(32'h1C000010, 32'h1C000100, 1'b1, 2'b01);
    upd(32'h1C000010, 32'h1C000014, 1'b0, 2'b01);
    fetch(32'h1C000010);
    check("ctr_sat_high", 32'(bp.pred_taken), 32'd1);
    upd(32'h1C000010, 32'h1C000014, 1'b0, 2'b01);
    fetch(32'h1C000010);
    check("ctr_weak_nt", 32'(bp.pred_taken), 32'd0);

    // Aliasing: JIRL at same index, different tag
    upd(32'h1C000010, 32'h1C000100, 1'b1, 2'b01);
    upd(32'h1C001010, 32'h00002000, 1'b1, 2'b11);
    fetch(32'h1C000010);
    check("alias_evict", bp.pred_pc_next, 32'h1C000014);
    fetch(32'h1C001010);
    check("alias_jirl", bp.pred_pc_next, 32'h00002000);
    upd(32'h1C001010, 32'h1C001014, 1'b0, 2'b11);  // ctr not used for indirect
    fetch(32'h1C001010);
    check("jirl_nt_keeps", bp.pred_pc_next, 32'h00002000);

    // Same-cycle read/write
    step(1'b0, 1'b1, 32'h1C000020, 1'b1, 32'h1C000020, 32'h1C000400, 1'b1, 2'b10, 1'b0);
    check("rbw_old", bp.pred_pc_next, 32'h1C000024);
    fetch(32'h1C000020);
    check("rbw_new", bp.pred_pc_next, 32'h1C000400);

    // Flush
    step(1'b0, 1'b1, 32'h1C000000, 1'b1, 32'h1C000020, 32'h1C000024, 1'b0, 2'b10, 1'b1);
    check("flush_valid", 32'(bp.pred_valid), 32'd0);
    check("flush_perf", bp.perf_mispredicts, 32'd1);

    // Wrap and ignored category
    fetch(32'hFFFFFFFC);
    check("wrap_next", bp.pred_pc_next, 32'h00000000);
    upd(32'h1C000030, 32'h1C000800, 1'b1, 2'b00);
    fetch(32'h1C000030);
    check("cat00_ignored", bp.pred_pc_next, 32'h1C000034);

    // Idle fetch holds outputs
    step(1'b0, 1'b0, 32'h12345678, 1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0);

    // Mid-operation reset
    step(1'b1, 1'b1, 32'h1C000020, 1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
    fetch(32'h1C000020);
    check("post_rst_miss", bp.pred_pc_next, 32'h1C000024);

    // Random phase over a small aliasing PC space
    for (int n = 0; n < 400; n++) begin
      logic [31:0] fpc, upc, tgt;
      fpc = 32'h1C000000 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 1)) << 8);
      upc = 32'h1C000000 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 1)) << 8);
      tgt = {$urandom_range(0, 32'h3FFFFFFF), 2'b00} ^ 32'($urandom_range(0, 3));
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), fpc,
           1'($urandom_range(0, 1)), upc, tgt, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
